// File: rtl/cmp_pkg.sv
// Shared types, default sizes and the round-robin pick helper for the
// comparator arbiter.
package cmp_pkg;

   localparam int CMP_N    = 4;
   localparam int CMP_NREQ = 4;
   localparam int RR_MAX   = 32;
   localparam int RR_IDXW  = $clog2(RR_MAX);

   typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

   typedef struct packed {
      logic        found;
      int unsigned idx;
   } rr_pick_t;

   // First set bit of valid at or above ptr, wrapping at nreq (nreq <= RR_MAX).
   function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] valid,
                                        input int unsigned        ptr,
                                        input int unsigned        nreq);
      rr_pick_t    r;
      int unsigned j;
      r.found = 1'b0;
      r.idx   = 0;
      for (int unsigned k = 0; k < RR_MAX; k++) begin
         if (k < nreq && !r.found) begin
            j = ptr + k;
            if (j >= nreq) j = j - nreq;
            if (valid[j[RR_IDXW-1:0]]) begin
               r.found = 1'b1;
               r.idx   = j;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/comparator.sv
// Unsigned magnitude comparator shared by the arbiter.
module comparator #(
   parameter int N = 4
) (
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         L,
   output logic         E,
   output logic         G
);

   always_comb begin
      L = (A < B);
      E = (A == B);
      G = (A > B);
   end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one comparator between NREQ requesters,
// returning a registered, tagged result over a valid/ready response channel.
module cmp_arbiter
   import cmp_pkg::*;
#(
   parameter int          N        = CMP_N,
   parameter int          NREQ     = CMP_NREQ,
   parameter int          IDW      = $clog2(NREQ),
   parameter logic [15:0] CNT_INIT = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*N-1:0] req_a,
   input  logic [NREQ*N-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic              rsp_l,
   output logic              rsp_e,
   output logic              rsp_g,
   output logic [15:0]       cmp_count
);

   state_t         state, state_nxt;
   rr_pick_t       pick;
   logic           grant_en;
   logic [IDW-1:0] grant_idx;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] rr_next;
   logic [IDW-1:0] op_id;
   logic [N-1:0]   op_a, op_b;
   logic           cmp_l, cmp_e, cmp_g;
   logic           rsp_fire;

   comparator #(.N(N)) u_cmp (
      .A (op_a),
      .B (op_b),
      .L (cmp_l),
      .E (cmp_e),
      .G (cmp_g)
   );

   always_comb begin
      pick = rr_pick(RR_MAX'(req_valid), 32'(rr_ptr), NREQ);
   end

   // The range guard keeps the full pick index meaningful for any NREQ.
   assign grant_idx = IDW'(pick.idx);
   assign rsp_fire  = (state == RESP) && rsp_valid && rsp_ready;
   assign rr_next   = (rsp_id == IDW'(NREQ-1)) ? '0 : rsp_id + 1'b1;

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      grant_en  = 1'b0;
      case (state)
         IDLE: begin
            if (pick.found && (pick.idx < NREQ)) begin
               req_ready[grant_idx] = 1'b1;
               grant_en             = 1'b1;
               state_nxt            = CMP;
            end
         end
         CMP: begin
            state_nxt = RESP;
         end
         RESP: begin
            if (rsp_fire) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a  <= '0;
         op_b  <= '0;
         op_id <= '0;
      end else if (grant_en) begin
         op_a  <= req_a[int'(grant_idx)*N +: N];
         op_b  <= req_b[int'(grant_idx)*N +: N];
         op_id <= grant_idx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_l     <= 1'b0;
         rsp_e     <= 1'b0;
         rsp_g     <= 1'b0;
      end else if (state == CMP) begin
         rsp_valid <= 1'b1;
         rsp_id    <= op_id;
         rsp_l     <= cmp_l;
         rsp_e     <= cmp_e;
         rsp_g     <= cmp_g;
      end else if (rsp_fire) begin
         rsp_valid <= 1'b0;
      end
   end

   // Pointer moves only on the response handshake so a stalled result keeps priority order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr    <= '0;
         cmp_count <= CNT_INIT;
      end else if (rsp_fire) begin
         rr_ptr    <= rr_next;
         cmp_count <= cmp_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter: a small arbitration model predicts grants,
// queues expected results at accept time and compares them at the response.
`timescale 1ns/1ps
module tb_cmp_arbiter;

   localparam int ST_IDLE = 0;
   localparam int ST_CMP  = 1;
   localparam int ST_RESP = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid, req_ready;
   logic [15:0] req_a, req_b;
   logic        rsp_valid, rsp_ready, rsp_l, rsp_e, rsp_g;
   logic [1:0]  rsp_id;
   logic [15:0] cmp_count;

   logic [3:0]  w_req_valid, w_req_ready;
   logic [15:0] w_req_a, w_req_b;
   logic        w_rsp_valid, w_rsp_ready, w_rsp_l, w_rsp_e, w_rsp_g;
   logic [1:0]  w_rsp_id;
   logic [15:0] w_cmp_count;

   typedef struct {
      int   id;
      logic l;
      logic e;
      logic g;
   } exp_t;

   exp_t        sb[$];
   int          resp_ids[$];
   int          resp_cyc[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          mst, mptr, cyc;
   logic [15:0] mcount, wcount;
   logic        hold_valid, wrapped;

   always #5 clk = ~clk;

   cmp_arbiter #(.N(4), .NREQ(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_l     (rsp_l),
      .rsp_e     (rsp_e),
      .rsp_g     (rsp_g),
      .cmp_count (cmp_count)
   );

   cmp_arbiter #(.N(4), .NREQ(4), .CNT_INIT(16'hFFFD)) dut_wrap (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (w_req_valid),
      .req_a     (w_req_a),
      .req_b     (w_req_b),
      .req_ready (w_req_ready),
      .rsp_valid (w_rsp_valid),
      .rsp_ready (w_rsp_ready),
      .rsp_id    (w_rsp_id),
      .rsp_l     (w_rsp_l),
      .rsp_e     (w_rsp_e),
      .rsp_g     (w_rsp_g),
      .cmp_count (w_cmp_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
      req_a[i*4 +: 4] = a;
      req_b[i*4 +: 4] = b;
   endtask

   task automatic model_reset();
      sb.delete();
      mst    = ST_IDLE;
      mptr   = 0;
      mcount = 16'h0000;
      wcount = 16'hFFFD;
   endtask

   // One clock: compare against the model, advance the model, cross the edge.
   task automatic step();
      logic [3:0] exp_rdy;
      logic [3:0] a, b;
      logic       found;
      int         g, j;
      exp_t       e;
      #1;
      check("w_cmp_count", w_cmp_count, wcount);
      if (w_rsp_valid) begin
         wcount = wcount + 16'd1;
         if (wcount == 16'h0000) wrapped = 1'b1;
      end
      exp_rdy = '0;
      found   = 1'b0;
      g       = 0;
      if (mst == ST_IDLE) begin
         for (int k = 0; k < 4; k++) begin
            j = (mptr + k) % 4;
            if (!found && req_valid[j]) begin
               found = 1'b1;
               g     = j;
            end
         end
      end
      if (found) exp_rdy[g] = 1'b1;
      check("req_ready", req_ready, exp_rdy);
      check("rsp_valid", rsp_valid, mst == ST_RESP);
      check("cmp_count", cmp_count, mcount);
      if (rsp_valid) begin
         check("lge_onehot", rsp_l + rsp_e + rsp_g, 1);
         if (sb.size() > 0) begin
            check("rsp_id", rsp_id, sb[0].id);
            check("rsp_lge", {rsp_l, rsp_e, rsp_g}, {sb[0].l, sb[0].e, sb[0].g});
         end else begin
            check("rsp_unexpected", sb.size(), 1);
         end
      end
      case (mst)
         ST_IDLE: if (found) begin
            a = req_a[g*4 +: 4];
            b = req_b[g*4 +: 4];
            e.id = g;
            e.l  = (a < b);
            e.e  = (a == b);
            e.g  = (a > b);
            sb.push_back(e);
            mst = ST_CMP;
         end
         ST_CMP: mst = ST_RESP;
         default: if (rsp_ready) begin
            e = sb.pop_front();
            mptr   = (e.id + 1) % 4;
            mcount = mcount + 16'd1;
            mst    = ST_IDLE;
            resp_ids.push_back(e.id);
            resp_cyc.push_back(cyc);
         end
      endcase
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (found && !hold_valid) req_valid[g] = 1'b0;
   endtask

   task automatic run_until_idle(input int maxc);
      int n = 0;
      while ((mst != ST_IDLE || sb.size() > 0 || req_valid != 4'b0000) && n < maxc) begin
         step();
         n++;
      end
      check("idle_timeout", n < maxc, 1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_req_ready"}, req_ready, 4'b0000);
      check({tag, "_rsp_valid"}, rsp_valid, 0);
      check({tag, "_rsp_id"}, rsp_id, 0);
      check({tag, "_rsp_lge"}, {rsp_l, rsp_e, rsp_g}, 3'b000);
      check({tag, "_cmp_count"}, cmp_count, 16'h0000);
      check({tag, "_w_cmp_count"}, w_cmp_count, 16'hFFFD);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      req_valid   = '0;
      req_a       = '0;
      req_b       = '0;
      rsp_ready   = 1'b0;
      w_req_valid = 4'b0001;
      w_req_a     = 16'h0001;
      w_req_b     = 16'h0002;
      w_rsp_ready = 1'b1;
      hold_valid  = 1'b0;
      wrapped     = 1'b0;
      cyc         = 0;
      model_reset();

      @(negedge clk);
      #1;
      check_reset_values("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // All four requesters continuously valid.
      set_op(0, 4'd0, 4'd15);
      set_op(1, 4'd7, 4'd7);
      set_op(2, 4'd15, 4'd0);
      set_op(3, 4'd5, 4'd9);
      hold_valid = 1'b1;
      rsp_ready  = 1'b1;
      req_valid  = 4'b1111;
      for (int n = 0; n < 40 && resp_ids.size() < 5; n++) step();
      req_valid  = '0;
      hold_valid = 1'b0;
      check("rr_resp_count", resp_ids.size(), 5);
      if (resp_ids.size() >= 5) begin
         check("rr_id0", resp_ids[0], 0);
         check("rr_id1", resp_ids[1], 1);
         check("rr_id2", resp_ids[2], 2);
         check("rr_id3", resp_ids[3], 3);
         check("rr_id4", resp_ids[4], 0);
         for (int k = 0; k < 4; k++)
            check("issue_interval", resp_cyc[k+1] - resp_cyc[k], 3);
      end
      run_until_idle(20);

      // Single requester 2: 9 vs 3 gives G.
      set_op(2, 4'b1001, 4'b0011);
      req_valid = 4'b0100;
      run_until_idle(20);

      // Back-pressure with operand change after capture.
      set_op(3, 4'd12, 4'd5);
      rsp_ready = 1'b0;
      req_valid = 4'b1000;
      step();
      req_a[12 +: 4] = 4'd0;
      set_op(1, 4'd3, 4'd3);
      req_valid[1] = 1'b1;
      for (int n = 0; n < 6; n++) step();
      rsp_ready = 1'b1;
      run_until_idle(20);

      // Equality sweep on requester 1.
      for (int v = 0; v < 16; v++) begin
         set_op(1, 4'(v), 4'(v));
         req_valid[1] = 1'b1;
         run_until_idle(12);
      end

      // Reset while a result is held in RESP.
      set_op(2, 4'd1, 4'd2);
      rsp_ready = 1'b0;
      req_valid = 4'b0100;
      for (int n = 0; n < 3; n++) step();
      check("pre_rst_rsp_valid", rsp_valid, 1);
      req_valid = '0;
      #2 rst_n = 1'b0;
      #1;
      check_reset_values("midrst");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      set_op(0, 4'd6, 4'd6);
      set_op(2, 4'd8, 4'd1);
      req_valid = 4'b0101;
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      #1;
      check("post_rst_grant", req_ready, 4'b0001);
      run_until_idle(30);

      check("wrap_seen", wrapped, 1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

Shares a single combinational `comparator` instance (operand width N, outputs L/E/G) between NREQ independent requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time in round-robin order, captures its operands, compares them, and returns a registered, tagged result on a single response channel with valid/ready back-pressure. It sits between client blocks needing magnitude compares and the shared comparator datapath.

## Interface
- `N`, 4: operand width in bits.
- `NREQ`, 4: number of requesters (≥2).
- `IDW`, $clog2(NREQ): requester-ID width.
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `req_valid` input, NREQ bits: per-requester request valid.
- `req_a` input, NREQ*N bits: operand A; requester i occupies bits [i*N +: N].
- `req_b` input, NREQ*N bits: operand B, same packing as `req_a`.
- `req_ready` output, NREQ bits: per-requester accept; at most one bit is high.
- `rsp_valid` output, 1 bit: result valid.
- `rsp_ready` input, 1 bit: consumer accepts result.
- `rsp_id` output, IDW bits: index of the requester the result belongs to.
- `rsp_l`, `rsp_e`, `rsp_g` outputs, 1 bit each: A<B, A==B, A>B. Exactly one is high while `rsp_valid` is high.
- `cmp_count` output, 16 bits: completed responses; wraps modulo 2^16.

## Operation
- FSM states: IDLE, CMP, RESP.
- **IDLE:**
  - Grant g = first i with `req_valid[i]`=1, searching from `rr_ptr` upward and wrapping at NREQ.
  - `req_ready[g]`=1 combinationally in the same cycle; `req_ready` = 0 if no valid.
  - On grant: capture `req_a[g]`, `req_b[g]` and g into operand/ID registers; go to CMP.
  - No valid: stay in IDLE.
- **CMP:**
  - The comparator is driven from the captured registers.
  - L/E/G are registered into `rsp_l/e/g`; `rsp_valid` is set; go to RESP.
- **RESP:**
  - Hold all `rsp_*` stable while `rsp_valid`=1 and `rsp_ready`=0.
  - On `rsp_valid && rsp_ready`:
    - clear `rsp_valid`
    - `rr_ptr` = (`rsp_id`+1) mod NREQ
    - `cmp_count` +1
    - go to IDLE
- `req_ready` is 0 in CMP and RESP. Requests arriving then wait; a requester must hold `req_valid` and operands stable until it sees `req_ready`.
- Unsigned compare only. Comparison operands are the captured values, so later changes on `req_a`/`req_b` do not affect an in-flight result.
- Deassertion of `req_valid` before grant withdraws the request; no error is flagged.

## Timing
- Reset values:
  - state IDLE
  - `rr_ptr` 0
  - `req_ready` 0
  - `rsp_valid` 0
  - `rsp_id` 0
  - `rsp_l/e/g` 0
  - `cmp_count` 0
  - operand registers 0
- Latency: accept in cycle T → `rsp_valid` high in cycle T+2 (CMP at T+1, registered at the T+1→T+2 edge).
- Minimum issue interval: 3 cycles (IDLE, CMP, RESP with `rsp_ready` already high).
- Fairness: with all NREQ requesting continuously, grants rotate 0,1,…,NREQ-1,0. No requester waits more than NREQ grants.
- `rr_ptr` advances only on response handshake, never on grant.
- Wrap: `cmp_count` 0xFFFF + 1 → 0x0000.
- Reset mid-operation: any state returns asynchronously to IDLE with reset values. The in-flight result is discarded, and the requester whose operands were captured is not re-served automatically.

## Structure
- Shared package `cmp_pkg`:
  - state enum {IDLE, CMP, RESP}
  - default constants N=4, NREQ=4
  - function `rr_pick(valid, ptr)` returning the grant index and a found flag
- Sub-module: one instance of the existing `comparator` (ports A, B, L, E, G), parameterised to N. The arbiter contains no comparison logic of its own.

## Test plan
- Reset: assert `rst_n`=0 mid-RESP, then release → all outputs at reset values, next grant goes to requester 0.
- Single requester 2: A=4'b1001, B=4'b0011, `rsp_ready`=1 → `req_ready[2]` in cycle T; `rsp_valid` at T+2 with `rsp_id`=2, `rsp_g`=1; `cmp_count`=1.
- All four requesters valid continuously:
  - operand pairs (0,15), (7,7), (15,0), (5,9)
  - response ids must be 0,1,2,3,0 with L,E,G,L respectively
  - issue every 3 cycles
- Back-pressure: hold `rsp_ready`=0 for 5 cycles → `rsp_*` stable, `req_ready`=0 throughout. Change `req_a` of the captured requester during the wait → result unchanged.
- Equality sweep: requester 1 with A=B for all 16 values → `rsp_e`=1 each time. Exactly one of L/E/G high on every response.
- Counter wrap: preload or run 65536 responses → `cmp_count` returns to 0 after 0xFFFF.
